// File: rtl/sd_byte_fifo_if.sv
// ---------------------------------------------------------------------------
// sd_byte_fifo_if
// Bundles the byte-stream handshake between the SD reader, the byte FIFO and
// the downstream consumer.
//   master : drives data_in/push (reader side) and pop/clr_flags (consumer
//            side); observes every FIFO status output.
//   slave  : the FIFO itself; takes the strobes, returns head byte and status.
// ADDR_WIDTH must match the FIFO's ADDR_WIDTH; count is ADDR_WIDTH+1 bits so
// that the full value DEPTH is representable.
// ---------------------------------------------------------------------------
interface sd_byte_fifo_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [7:0]          data_in;
    logic                push;
    logic                pop;
    logic                clr_flags;
    logic [7:0]          data_out;
    logic                empty;
    logic                full;
    logic [ADDR_WIDTH:0] count;
    logic                overflow;
    logic                underflow;
    logic                sector_done;
    logic [7:0]          sector_count;

    modport master (
        output data_in, push, pop, clr_flags,
        input  data_out, empty, full, count, overflow, underflow,
               sector_done, sector_count
    );

    modport slave (
        input  data_in, push, pop, clr_flags,
        output data_out, empty, full, count, overflow, underflow,
               sector_done, sector_count
    );
endinterface

// File: rtl/sd_byte_fifo.sv
// ---------------------------------------------------------------------------
// sd_byte_fifo
// First-word-fall-through byte FIFO between the SD card reader deserializer
// and a downstream consumer, with sticky overflow/underflow flags and SD
// sector (data block) accounting.
// Ports:
//   clock        rising-edge clock for all state
//   reset        asynchronous active-low reset of all control state
//   bus (slave)  data_in/push   : byte and write strobe from the reader
//                pop/clr_flags  : read strobe, sticky-flag clear
//                data_out       : head byte, valid while empty=0
//                empty/full/count, overflow/underflow (sticky)
//                sector_done    : one-cycle pulse after a sector's last byte
//                sector_count   : completed sectors, modulo 256
// ---------------------------------------------------------------------------
module sd_byte_fifo #(
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int SECTOR_BYTES = 512
) (
    input  logic          clock,
    input  logic          reset,
    sd_byte_fifo_if.slave bus
);
    localparam int BC_W = (SECTOR_BYTES > 1) ? $clog2(SECTOR_BYTES) : 1;
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [BC_W-1:0]     LAST_BYTE  = BC_W'(SECTOR_BYTES - 1);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
            (ADDR_WIDTH != $clog2(DEPTH))) begin : g_bad_param
            $error("sd_byte_fifo: DEPTH must be a power of two >= 2 and ADDR_WIDTH = log2(DEPTH)");
        end
    endgenerate

    logic [7:0]            mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic [BC_W-1:0]       byte_cnt;
    logic [7:0]            sector_cnt_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  sector_done_q;

    logic empty_w;
    logic full_w;
    logic push_ok;
    logic pop_ok;
    logic push_drop;
    logic pop_drop;
    logic sector_end;

    // Status comes from the occupancy counter alone; with power-of-two
    // wrapping pointers, wr_ptr == rd_ptr is ambiguous between empty and full.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == COUNT_FULL);

    // A pop on a full FIFO frees the head slot in the same edge, so a
    // simultaneous push may write there (wr_ptr == rd_ptr when full).
    assign push_ok    = bus.push && (!full_w || bus.pop);
    assign pop_ok     = bus.pop && !empty_w;
    assign push_drop  = bus.push && full_w && !bus.pop;
    assign pop_drop   = bus.pop && empty_w;
    assign sector_end = push_ok && (byte_cnt == LAST_BYTE);

    // Storage: data only, never reset.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // Control: pointers, occupancy, flags and sector accounting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count_q       <= '0;
            byte_cnt      <= '0;
            sector_cnt_q  <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            sector_done_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            if (push_ok && !pop_ok) begin
                count_q <= count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - 1'b1;
            end

            // Clear first so that an error in the same cycle still sets.
            if (bus.clr_flags) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end
            if (push_drop) begin
                overflow_q <= 1'b1;
            end
            if (pop_drop) begin
                underflow_q <= 1'b1;
            end

            // Only accepted bytes advance the in-sector position.
            if (push_ok) begin
                byte_cnt <= sector_end ? '0 : byte_cnt + 1'b1;
            end
            sector_done_q <= sector_end;
            if (sector_end) begin
                sector_cnt_q <= sector_cnt_q + 1'b1;
            end
        end
    end

    assign bus.data_out     = mem[rd_ptr];
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.sector_done  = sector_done_q;
    assign bus.sector_count = sector_cnt_q;
endmodule

// File: tb/tb_sd_byte_fifo.sv
// ---------------------------------------------------------------------------
// tb_sd_byte_fifo
// Self-checking bench for sd_byte_fifo (DEPTH=16, SECTOR_BYTES=512).
// A queue holds the bytes the FIFO should contain; bytes are appended when an
// accepted push is driven and removed/compared when an accepted pop is driven.
// ---------------------------------------------------------------------------
module tb_sd_byte_fifo;
    localparam int DEPTH        = 16;
    localparam int ADDR_WIDTH   = 4;
    localparam int SECTOR_BYTES = 512;

    logic clock;
    logic reset;

    sd_byte_fifo_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

    sd_byte_fifo #(
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .SECTOR_BYTES(SECTOR_BYTES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // One clock of stimulus; inputs change #1 after the rising edge.
    task automatic drive(input logic p, input logic [7:0] d, input logic po, input logic clr);
        logic acc_push;
        logic acc_pop;
        logic [7:0] exp_byte;
        bus.push      = p;
        bus.data_in   = d;
        bus.pop       = po;
        bus.clr_flags = clr;
        acc_pop  = po && (exp_q.size() != 0);
        acc_push = p && ((exp_q.size() != DEPTH) || po);
        if (acc_pop) begin
            exp_byte = exp_q.pop_front();
            checks++;
            if (bus.data_out !== exp_byte) begin
                errors++;
                $display("FAIL pop_data: got %02h expected %02h", bus.data_out, exp_byte);
            end
        end
        if (acc_push) exp_q.push_back(d);
        @(posedge clock);
        #1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.clr_flags = 1'b0;
    endtask

    task automatic do_reset();
        bus.push = 1'b0; bus.pop = 1'b0; bus.clr_flags = 1'b0; bus.data_in = 8'h00;
        reset = 1'b0;
        exp_q.delete();
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        bus.push = 1'b0; bus.pop = 1'b0; bus.clr_flags = 1'b0; bus.data_in = 8'h00;
        reset = 1'b0;
        exp_q.delete();
        repeat (2) begin @(posedge clock); #1; end
        checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: count=%0d empty=%b full=%b expected 0/1/0", bus.count, bus.empty, bus.full);
        end
        checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.sector_done !== 1'b0 || bus.sector_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_flags: ovf=%b unf=%b sd=%b sc=%0d expected all 0",
                     bus.overflow, bus.underflow, bus.sector_done, bus.sector_count);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL reset_release: empty=%b count=%0d expected 1/0", bus.empty, bus.count);
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        drive(1'b1, 8'h33, 1'b0, 1'b0);
        checks++;
        if (bus.count !== 5'd3 || bus.data_out !== 8'h11 || bus.empty !== 1'b0) begin
            errors++;
            $display("FAIL basic_fill: count=%0d head=%02h empty=%b expected 3/11/0", bus.count, bus.data_out, bus.empty);
        end
        repeat (3) drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL basic_drain: empty=%b count=%0d expected 1/0", bus.empty, bus.count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_fill: full=%b count=%0d ovf=%b expected 1/16/0", bus.full, bus.count, bus.overflow);
        end
        drive(1'b1, 8'h10, 1'b0, 1'b0);
        checks++;
        if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: full=%b count=%0d ovf=%b expected 1/16/1", bus.full, bus.count, bus.overflow);
        end
        repeat (16) drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_drain: empty=%b count=%0d expected 1/0", bus.empty, bus.count);
        end
    endtask

    task automatic test_full_push_pop();
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_clr: ovf=%b expected 0", bus.overflow);
        end
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hAA, 1'b1, 1'b0);
        checks++;
        if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_both: count=%0d full=%b ovf=%b expected 16/1/0", bus.count, bus.full, bus.overflow);
        end
        repeat (15) drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bus.data_out !== 8'hAA || bus.count !== 5'd1) begin
            errors++;
            $display("FAIL fpp_last: head=%02h count=%0d expected AA/1", bus.data_out, bus.count);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL fpp_empty: empty=%b expected 1", bus.empty);
        end
    endtask

    task automatic test_empty_push_pop();
        drive(1'b1, 8'h5C, 1'b1, 1'b0);
        checks++;
        if (bus.count !== 5'd1 || bus.underflow !== 1'b1 || bus.data_out !== 8'h5C) begin
            errors++;
            $display("FAIL epp_both: count=%0d unf=%b head=%02h expected 1/1/5C", bus.count, bus.underflow, bus.data_out);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (bus.underflow !== 1'b0 || bus.count !== 5'd1) begin
            errors++;
            $display("FAIL epp_clr: unf=%b count=%0d expected 0/1", bus.underflow, bus.count);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        checks++;
        if (bus.underflow !== 1'b1 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL epp_setwins: unf=%b empty=%b expected 1/1", bus.underflow, bus.empty);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_sector_stream();
        int pulses = 0;
        int first  = -1;
        int second = -1;
        do_reset();
        for (int i = 0; i < 1024; i++) begin
            drive(1'b1, 8'(i * 7 + 3), 1'b1, 1'b0);
            if (bus.sector_done === 1'b1) begin
                pulses++;
                if (first < 0) first = i; else second = i;
            end
        end
        checks++;
        if (pulses != 2 || first != 511 || second != 1023) begin
            errors++;
            $display("FAIL stream_pulses: got %0d pulses at %0d,%0d expected 2 at 511,1023", pulses, first, second);
        end
        checks++;
        if (bus.sector_count !== 8'd2) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 2", bus.sector_count);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (bus.sector_done !== 1'b0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL stream_tail: sd=%b empty=%b expected 0/1", bus.sector_done, bus.empty);
        end
    endtask

    task automatic test_reset_mid_sector();
        int pulses = 0;
        int first  = -1;
        do_reset();
        for (int i = 0; i < 300; i++) drive(1'b1, 8'(i), 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.sector_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_async: count=%0d empty=%b sc=%0d expected 0/1/0", bus.count, bus.empty, bus.sector_count);
        end
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        for (int i = 0; i < 512; i++) begin
            drive(1'b1, 8'(i + 5), 1'b1, 1'b0);
            if (bus.sector_done === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (pulses != 1 || first != 511) begin
            errors++;
            $display("FAIL rst_sector: got %0d pulses first at %0d expected 1 at 511", pulses, first);
        end
        checks++;
        if (bus.sector_count !== 8'd1) begin
            errors++;
            $display("FAIL rst_count: got %0d expected 1", bus.sector_count);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_sector_stream();
        test_reset_mid_sector();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
